nspi_frame_sequencer: RTL and testbench

NSPI_FRAME_SEQUENCER -- requirements
Module: nspi_frame_sequencer

---
 rtl/nspi_pkg.sv | 22 ++
 rtl/nspi_frame_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_nspi_frame_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/nspi_pkg.sv
// Shared definitions for the NSPI frame sequencer and transmitter-side blocks:
// sequencer state encoding and counter-width helper.
package nspi_pkg;

   localparam int unsigned NSPI_STATE_W = 3;

   typedef enum logic [NSPI_STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_REQ   = 3'd3,
      ST_ACK   = 3'd4,
      ST_DRAIN = 3'd5,
      ST_GAP   = 3'd6
   } nspi_state_e;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int unsigned nspi_cnt_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/nspi_frame_sequencer.sv
// Frame sequencer: walks a word buffer and hands each word to the SPI transmitter.
// Optional handshake watchdog enabled by defining NSPI_SEQ_TIMEOUT_EN.
module nspi_frame_sequencer
   import nspi_pkg::*;
#(
   parameter  int unsigned CHANNEL_NUMBER = 3,
   parameter  int unsigned SPI_SIZE       = 8,
   parameter  int unsigned FRAME_WORDS    = 128,
   parameter  int unsigned GAP_CYCLES     = 16,
   parameter  int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned ADDR_W         = nspi_cnt_width(FRAME_WORDS)
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    frame_start,
   output logic                                    busy,
   output logic                                    frame_done,
   output logic                                    rd_en,
   output logic [ADDR_W-1:0]                       rd_addr,
   input  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] rd_data,
   output logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] data_out,
   output logic                                    start_tx,
   input  logic                                    tx_finish,
   output logic                                    timeout_err
);

   localparam int unsigned     GAP_W    = nspi_cnt_width(GAP_CYCLES);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 32'd1);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 32'd0) ? (GAP_CYCLES - 32'd1) : 32'd0);

   // Reject parameter sets the datapath cannot represent.
   if ((FRAME_WORDS < 32'd1) || ((SPI_SIZE != 32'd8) && (SPI_SIZE != 32'd16)) ||
       (TIMEOUT_CYCLES < 32'd1)) begin : g_bad_cfg
      $error("nspi_frame_sequencer: unsupported parameter set");
   end

   nspi_state_e                             state_q, state_d;
   logic [ADDR_W-1:0]                       idx_q, idx_d;
   logic [GAP_W-1:0]                        gap_cnt_q, gap_cnt_d;
   logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] data_out_q, data_out_d;
   logic                                    busy_q, busy_d;
   logic                                    frame_done_q, frame_done_d;
   logic                                    rd_en_q, rd_en_d;
   logic                                    start_tx_q, start_tx_d;

`ifdef NSPI_SEQ_TIMEOUT_EN
   localparam int unsigned     TMO_W    = nspi_cnt_width(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'd1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             timeout_err_q, timeout_err_d;
`endif

   // Next-state and next-output decode; output registers mirror the state being entered.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      gap_cnt_d    = gap_cnt_q;
      data_out_d   = data_out_q;
      frame_done_d = 1'b0;
`ifdef NSPI_SEQ_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
      timeout_err_d = timeout_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (frame_start && tx_finish) begin
               state_d = ST_FETCH;
               idx_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            data_out_d = rd_data;
            state_d    = ST_REQ;
`ifdef NSPI_SEQ_TIMEOUT_EN
            tmo_cnt_d  = '0;
`endif
         end
         ST_REQ: begin
            if (!tx_finish) begin
               state_d = ST_ACK;
`ifdef NSPI_SEQ_TIMEOUT_EN
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
`else
            end else begin
               state_d = ST_REQ;
`endif
            end
         end
         ST_ACK: begin
            if (tx_finish) begin
               state_d = ST_DRAIN;
`ifdef NSPI_SEQ_TIMEOUT_EN
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
`else
            end else begin
               state_d = ST_ACK;
`endif
            end
         end
         ST_DRAIN: begin
            if (idx_q == LAST_IDX) begin
               if (GAP_CYCLES == 32'd0) begin
                  state_d      = ST_IDLE;
                  frame_done_d = 1'b1;
               end else begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d     = (state_d != ST_IDLE);
      rd_en_d    = (state_d == ST_FETCH);
      start_tx_d = (state_d == ST_REQ);
   end

   // State, index, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         gap_cnt_q    <= '0;
         data_out_q   <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         rd_en_q      <= 1'b0;
         start_tx_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         gap_cnt_q    <= gap_cnt_d;
         data_out_q   <= data_out_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         rd_en_q      <= rd_en_d;
         start_tx_q   <= start_tx_d;
      end
   end

`ifdef NSPI_SEQ_TIMEOUT_EN
   // Handshake watchdog; the error flag is sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign rd_en      = rd_en_q;
   assign rd_addr    = idx_q;
   assign data_out   = data_out_q;
   assign start_tx   = start_tx_q;

endmodule

// File: tb/tb_nspi_frame_sequencer.sv
// Self-checking bench: a 4-word/16-gap sequencer driven by a randomized transmitter
// and buffer model, plus a 1-word/zero-gap sequencer checked cycle by cycle.
module tb_nspi_frame_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic            a_frame_start, a_busy, a_frame_done, a_rd_en, a_start_tx, a_tx_finish, a_timeout_err;
   logic [1:0]      a_rd_addr;
   logic [2:0][7:0] a_rd_data, a_data_out;

   logic             b_frame_start, b_busy, b_frame_done, b_rd_en, b_start_tx, b_tx_finish, b_timeout_err;
   logic [0:0]       b_rd_addr;
   logic [1:0][15:0] b_rd_data, b_data_out;

   nspi_frame_sequencer #(
      .CHANNEL_NUMBER(3), .SPI_SIZE(8), .FRAME_WORDS(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(32)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .frame_start(a_frame_start), .busy(a_busy),
      .frame_done(a_frame_done), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
      .data_out(a_data_out), .start_tx(a_start_tx), .tx_finish(a_tx_finish),
      .timeout_err(a_timeout_err)
   );

   nspi_frame_sequencer #(
      .CHANNEL_NUMBER(2), .SPI_SIZE(16), .FRAME_WORDS(1), .GAP_CYCLES(0), .TIMEOUT_CYCLES(32)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .frame_start(b_frame_start), .busy(b_busy),
      .frame_done(b_frame_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .data_out(b_data_out), .start_tx(b_start_tx), .tx_finish(b_tx_finish),
      .timeout_err(b_timeout_err)
   );

   int          vec_cnt  = 0;
   int          miss_cnt = 0;
   int          cyc      = 0;
   logic [23:0] mem_a [4];
   logic [31:0] mem_b;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_a_busy"},       a_busy, 0);
      chk({pfx, "_a_frame_done"}, a_frame_done, 0);
      chk({pfx, "_a_rd_en"},      a_rd_en, 0);
      chk({pfx, "_a_rd_addr"},    a_rd_addr, 0);
      chk({pfx, "_a_start_tx"},   a_start_tx, 0);
      chk({pfx, "_a_data_out"},   a_data_out, 0);
      chk({pfx, "_a_timeout"},    a_timeout_err, 0);
      chk({pfx, "_b_busy"},       b_busy, 0);
      chk({pfx, "_b_start_tx"},   b_start_tx, 0);
      chk({pfx, "_b_data_out"},   b_data_out, 0);
   endtask

   // One frame on dut_b: FETCH, LOAD, REQ, ACK, DRAIN, then frame_done with no gap.
   task automatic run_frame_b();
      mem_b         = $urandom();
      b_frame_start = 1'b1;
      b_tx_finish   = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         b_frame_start = 1'b0;
         b_rd_data     = (k == 2) ? mem_b : $urandom();
         chk("b_rd_en", b_rd_en, (k == 1));
         chk("b_start_tx", b_start_tx, (k == 3));
         chk("b_frame_done", b_frame_done, (k == 6));
         chk("b_busy", b_busy, (k >= 1 && k <= 5));
         if (k == 1) chk("b_rd_addr", b_rd_addr, 0);
         if (k == 3) begin
            chk("b_data_out", b_data_out, mem_b);
            b_tx_finish = 1'b0;
         end
         if (k == 4) b_tx_finish = 1'b1;
      end
   endtask

   // One frame on dut_a against a timing model derived from the handshake rules.
   task automatic run_frame_a(input int pre_low, input bit extra_starts, input int abort_word);
      int         exp_req, exp_fetch, exp_done, n_fetch, hs, dones, tstate, delay, low_len, low_cnt;
      bit         pv_en, aborted;
      logic [1:0] pv_addr;
      for (int w = 0; w < 4; w++) mem_a[w] = 24'($urandom());
      a_frame_start = 1'b1;
      a_tx_finish   = 1'b0;
      for (int i = 0; i < pre_low; i++) begin
         tick();
         chk("txlow_busy", a_busy, 0);
         chk("txlow_rd_en", a_rd_en, 0);
      end
      a_tx_finish = 1'b1;
      exp_fetch = cyc + 1;
      exp_req   = cyc + 3;
      exp_done  = -1;
      n_fetch = 0; hs = 0; dones = 0; tstate = 0; delay = 0; low_len = 1; low_cnt = 0;
      pv_en = 1'b0; pv_addr = 2'd0; aborted = 1'b0;
      for (int budget = 0; budget < 400; budget++) begin
         tick();
         if (abort_word >= 0 && hs == abort_word + 1 && tstate == 2) begin
            rst_n = 1'b0;
            #1;
            chk_zero("midreset");
            a_tx_finish   = 1'b1;
            a_frame_start = 1'b0;
            repeat (3) begin
               tick();
               chk("midreset_done", a_frame_done, 0);
               chk("midreset_busy", a_busy, 0);
            end
            rst_n   = 1'b1;
            aborted = 1'b1;
            break;
         end
         a_rd_data = pv_en ? mem_a[pv_addr] : 24'($urandom());
         if (a_rd_en) begin
            chk("rd_en_cycle", cyc, exp_fetch);
            chk("rd_addr", a_rd_addr, n_fetch);
            n_fetch++;
         end
         pv_en   = a_rd_en;
         pv_addr = a_rd_addr;
         if (exp_done < 0 || cyc < exp_done) chk("busy_in_frame", a_busy, 1);
         if (a_frame_done) begin
            chk("frame_done_cycle", cyc, exp_done);
            chk("busy_at_done", a_busy, 0);
            dones++;
         end
         if (tstate == 2) begin
            if (low_cnt == 0) chk("start_tx_drop", a_start_tx, 0);
            chk("data_out_stable", a_data_out, mem_a[hs-1]);
            low_cnt++;
            if (low_cnt == low_len) begin
               a_tx_finish = 1'b1;
               tstate      = 0;
               if (hs == 4) begin
                  exp_done = cyc + 2 + 16;
               end else begin
                  exp_fetch = cyc + 2;
                  exp_req   = cyc + 4;
               end
            end
         end else if (tstate == 1) begin
            chk("start_tx_held", a_start_tx, 1);
            if (delay == 0) begin
               a_tx_finish = 1'b0;
               low_cnt     = 0;
               tstate      = 2;
            end else begin
               delay--;
            end
         end else if (a_start_tx) begin
            chk("start_tx_cycle", cyc, exp_req);
            chk("data_out", a_data_out, mem_a[hs]);
            hs++;
            delay   = $urandom_range(0, 3);
            low_len = $urandom_range(1, 5);
            tstate  = 1;
         end
         a_frame_start = (extra_starts && (exp_done < 0 || cyc < exp_done)) ?
                         1'($urandom_range(0, 1)) : 1'b0;
         if (dones > 0 && cyc >= exp_done + 2) break;
      end
      a_frame_start = 1'b0;
      if (!aborted) begin
         chk("handshakes", hs, 4);
         chk("words_fetched", n_fetch, 4);
         chk("frame_done_count", dones, 1);
         chk("timeout_clear", a_timeout_err, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a_frame_start = 1'b0; a_tx_finish = 1'b1; a_rd_data = '0;
      b_frame_start = 1'b0; b_tx_finish = 1'b1; b_rd_data = '0;
      repeat (3) tick();
      chk_zero("reset");
      rst_n = 1'b1;
      tick();
      chk_zero("post_reset");

      run_frame_b();
      run_frame_b();
      run_frame_a(0, 1'b0, -1);
      run_frame_a(5, 1'b0, -1);
      run_frame_a(0, 1'b1, -1);
      run_frame_a(0, 1'b0, 2);
      run_frame_a(0, 1'b0, -1);
      for (int f = 0; f < 4; f++) run_frame_a($urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
      run_frame_b();

`ifdef NSPI_SEQ_TIMEOUT_EN
      begin
         int r;
         a_tx_finish   = 1'b1;
         a_frame_start = 1'b1;
         r = cyc + 3;
         while (cyc < r + 34) begin
            tick();
            a_frame_start = 1'b0;
            if (cyc >= r && cyc < r + 32) begin
               chk("tmo_req_start_tx", a_start_tx, 1);
               chk("tmo_req_err", a_timeout_err, 0);
            end else if (cyc >= r + 32) begin
               chk("tmo_err", a_timeout_err, 1);
               chk("tmo_start_tx", a_start_tx, 0);
               chk("tmo_busy", a_busy, 0);
               chk("tmo_frame_done", a_frame_done, 0);
            end
         end
         rst_n = 1'b0;
         #1;
         chk("tmo_reset_clear", a_timeout_err, 0);
         tick();
         rst_n = 1'b1;
      end
`endif

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
